nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder that streams operand nibbles, with a registered carry, into
//  one adder_4_bit instance (ports A,B,Cin,S,Cout), one nibble per clock, LSB nibble first.
//  Sits directly upstream of adder_4_bit: sequences its inputs and collects S/Cout.
//  Trades latency for area: one 4-bit adder serves any WIDTH.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4, >= 8
//  NIB    WIDTH/4 (localparam)  number of nibble steps per addition
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  operand A, captured when start is accepted
//  b         in   WIDTH  operand B, captured when start is accepted
//  cin       in   1      carry-in, captured when start is accepted
//  busy      out  1      high in RUN and DONE; start is ignored while high
//  done      out  1      one-cycle pulse: result valid
//  sum       out  WIDTH  result, held until the next completion
//  cout      out  1      carry out of the MSB nibble
//  overflow  out  1      two's-complement overflow of a+b+cin
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; busy, done, sum, cout, overflow, nibble counter,
//   carry register and work registers all 0. Reset wins over every other event, including
//   reset mid-RUN: the partial result is discarded and no done pulse is issued.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge k -> latch a, b, cin into a_r, b_r, c_r; cnt=0; go to RUN.
//   RUN: adder inputs A=a_r[4*cnt+:4], B=b_r[4*cnt+:4], Cin=c_r.
//    Each edge: w_r[4*cnt+:4] <= S; c_r <= Cout; cnt <= cnt+1.
//    When cnt==NIB-1: go to DONE; sum <= {S, w_r lower bits}; cout <= Cout;
//     overflow <= (a_r[MSB]==b_r[MSB]) && (S[3]!=a_r[MSB]).
//   DONE: done=1 for exactly one cycle, then unconditional go to IDLE.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+NIB
//   (NIB edges later). Back-to-back throughput: one result per NIB+2 cycles (start held high).
//  busy is 1 from the cycle after acceptance through the DONE cycle; it is registered.
//  start while busy (RUN or DONE): ignored; operands are not re-latched.
//  Inputs a, b, cin may change freely after acceptance without affecting the result.
//  sum/cout/overflow change only on the edge entering DONE (or on reset); never show
//   partial results.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); the carry chains between
//   nibbles through c_r only, with no combinational path from a/b to outputs.
//  cnt width is clog2(NIB); no wrap occurs because the FSM leaves RUN at NIB-1.
// TESTING (WIDTH=16)
//  0x6969+0x9696, cin=0 -> sum=0xFFFF, cout=0, overflow=0; done exactly 4 edges after start.
//  0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1, overflow=0 (carry rippled through all nibbles).
//  0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; 0x8000+0x8000 -> 0x0000, cout=1, ov=1.
//  Pulse start mid-RUN with a=0x1111 -> ignored; first result is unchanged; busy is never dropped early.
//  Assert rst at the 2nd RUN cycle -> next cycle busy=0, sum=0, no done pulse; a new start then works.
//  Hold start=1 continuously with a=1, b=2 -> done every 6 cycles, sum=0x0003 each time;
//   change a after acceptance -> no effect.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams operand nibbles LSB-first through one
// 4-bit adder with a registered carry, one nibble per clock.

module adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one nibble per clock through the 4-bit adder, carry held in c_r
// DONE  | result registered, done pulses for one cycle
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-5:0] w_r;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_nib;
  logic             last;

  assign a_nib = a_r[4*cnt +: 4];
  assign b_nib = b_r[4*cnt +: 4];
  assign last  = (cnt == CW'(NIB - 1));

  adder_4_bit u_add (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (c_r),
    .S    (s_nib),
    .Cout (c_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      w_r      <= '0;
      c_r      <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          c_r <= c_nib;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Top nibble goes straight to sum; w_r only holds the lower nibbles.
            sum      <= {s_nib, w_r};
            cout     <= c_nib;
            overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_nib[3] != a_r[WIDTH-1]);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            w_r[4*cnt +: 4] <= s_nib;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases plus
// randomized traffic compared every cycle against a transaction-level model.

module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] sum;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: phase = cycles since acceptance (-1 when idle).
  int               phase = -1;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ov = 1'b0;
  logic [WIDTH-1:0] p_sum;
  logic             p_cout, p_ov;
  bit               chk_en = 1'b0;

  function automatic void ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c, output logic [WIDTH-1:0] s,
                                  output logic co, output logic ov);
    longint ux, uy, sx, sy, tot, stot;
    ux = longint'(x);
    uy = longint'(y);
    tot = ux + uy + longint'(c);
    s  = tot[WIDTH-1:0];
    co = tot[WIDTH];
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    stot = sx + sy + longint'(c);
    ov = (stot > 32767) || (stot < -32768);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      phase  = -1;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ov   = 1'b0;
      chk_en = 1'b1;
    end else if (phase < 0) begin
      if (start) begin
        ref_add(a, b, cin, p_sum, p_cout, p_ov);
        phase = 0;
      end
    end else begin
      phase++;
      if (phase == NIB) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ov   = p_ov;
      end else if (phase == NIB + 1) begin
        phase = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(phase >= 0));
      chk("done", 32'(done), 32'(phase == NIB));
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  // Directed op: one-cycle start pulse, bounded wait for done, literal checks.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    bit seen;
    logic [WIDTH-1:0] ms;
    logic mc, mo;
    ref_add(xa, xb, xc, ms, mc, mo);
    chk("model_sum", 32'(ms), 32'(es));
    chk("model_cout", 32'(mc), 32'(ec));
    chk("model_ov", 32'(mo), 32'(eo));
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(NIB));
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_ov", 32'(overflow), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    int t0, npulse, gap_bad, last_cyc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);

    run_op(16'h6969, 16'h9696, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ignore_sum", 32'(sum), 32'h2345);
    repeat (2) @(negedge clk);

    // reset during the second RUN cycle
    start = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // start held high: one result every NIB+2 cycles, a changed after acceptance
    start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    npulse = 0; gap_bad = 0; last_cyc = -1; t0 = cyc;
    while (cyc - t0 < 40) begin
      @(posedge clk);
      #1;
      if (done) begin
        chk("hold_sum", 32'(sum), 32'h0003);
        if (last_cyc >= 0) chk("hold_period", 32'(cyc - last_cyc), 32'(NIB + 2));
        last_cyc = cyc;
        npulse++;
      end
      a = (phase >= 1 && phase < NIB) ? 16'hABCD : 16'h0001;
    end
    chk("hold_pulses", 32'(npulse >= 5), 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (NIB + 3) @(negedge clk);

    // randomized traffic, occasional reset
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      cin = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom_range(0, 1) ? 16'hFFFF : 16'h8000;
        b = $urandom_range(0, 1) ? 16'h7FFF : 16'h0000;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (NIB + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
